// File: rtl/clk_pattern_gen.sv
// Multi-channel clock/strobe pattern generator: per-channel delay, low and high
// times, common start/stop. Optional rising-edge counters: CLK_PATTERN_GEN_EDGE_CNT_EN.
module clk_pattern_gen #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [N_CH*CNT_W-1:0]  cfg_delay,
    input  logic [N_CH*CNT_W-1:0]  cfg_neg,
    input  logic [N_CH*CNT_W-1:0]  cfg_pos,
`ifdef CLK_PATTERN_GEN_EDGE_CNT_EN
    input  logic                   edge_cnt_clr,
    output logic [N_CH*32-1:0]     edge_cnt,
`endif
    output logic [N_CH-1:0]        clock_out,
    output logic [N_CH-1:0]        clock_out_n,
    output logic [N_CH-1:0]        rise_stb,
    output logic [N_CH-1:0]        busy
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_LOW, S_HIGH} state_t;

    function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int = rst_sync[1];

    // Commands and config are registered first; channels act one edge later.
    logic             start_q;
    logic             stop_q;
    logic [N_CH-1:0]  en_q;
    logic [CNT_W-1:0] dly_q [N_CH];
    logic [CNT_W-1:0] neg_q [N_CH];
    logic [CNT_W-1:0] pos_q [N_CH];

    always_ff @(posedge clock or negedge rst_int) begin
        if (!rst_int) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            en_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dly_q[i] <= '0;
                neg_q[i] <= '0;
                pos_q[i] <= '0;
            end
        end else begin
            start_q <= start;
            stop_q  <= stop;
            if (start) begin
                en_q <= ch_en;
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_en[i]) begin
                        dly_q[i] <= cfg_delay[i*CNT_W +: CNT_W];
                        neg_q[i] <= min1(cfg_neg[i*CNT_W +: CNT_W]);
                        pos_q[i] <= min1(cfg_pos[i*CNT_W +: CNT_W]);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           st;
        logic [CNT_W-1:0] cnt;
        logic             pend;
        logic             co;
        logic             con;
        logic             rs;
        logic             rise_now;

        assign rise_now = !start_q && !stop_q && (st == S_LOW) && (cnt == CNT_W'(1));

        always_ff @(posedge clock or negedge rst_int) begin
            if (!rst_int) begin
                st   <= S_IDLE;
                cnt  <= '0;
                pend <= 1'b0;
                co   <= IDLE_LEVEL;
                con  <= ~IDLE_LEVEL;
                rs   <= 1'b0;
            end else begin
                rs <= 1'b0;
                if (start_q) begin
                    pend <= 1'b0;
                    if (en_q[i]) begin
                        co  <= 1'b0;
                        con <= 1'b1;
                        if (dly_q[i] != '0) begin
                            st  <= S_DELAY;
                            cnt <= dly_q[i];
                        end else begin
                            st  <= S_LOW;
                            cnt <= neg_q[i];
                        end
                    end else begin
                        st  <= S_IDLE;
                        cnt <= '0;
                        co  <= IDLE_LEVEL;
                        con <= ~IDLE_LEVEL;
                    end
                end else begin
                    case (st)
                        S_IDLE: pend <= 1'b0;
                        S_DELAY, S_LOW: begin
                            if (stop_q) begin
                                st  <= S_IDLE;
                                cnt <= '0;
                                co  <= IDLE_LEVEL;
                                con <= ~IDLE_LEVEL;
                            end else if (cnt == CNT_W'(1)) begin
                                if (st == S_DELAY) begin
                                    st  <= S_LOW;
                                    cnt <= neg_q[i];
                                end else begin
                                    st  <= S_HIGH;
                                    cnt <= pos_q[i];
                                    co  <= 1'b1;
                                    con <= 1'b0;
                                    rs  <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                        S_HIGH: begin
                            // A stop never cuts a high phase short.
                            if (cnt == CNT_W'(1)) begin
                                if (pend || stop_q) begin
                                    st   <= S_IDLE;
                                    cnt  <= '0;
                                    pend <= 1'b0;
                                    co   <= IDLE_LEVEL;
                                    con  <= ~IDLE_LEVEL;
                                end else begin
                                    st  <= S_LOW;
                                    cnt <= neg_q[i];
                                    co  <= 1'b0;
                                    con <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                                if (stop_q) pend <= 1'b1;
                            end
                        end
                        default: st <= S_IDLE;
                    endcase
                end
            end
        end

        assign clock_out[i]   = co;
        assign clock_out_n[i] = con;
        assign rise_stb[i]    = rs;
        assign busy[i]        = (st != S_IDLE);

`ifdef CLK_PATTERN_GEN_EDGE_CNT_EN
        logic [31:0] ec;

        always_ff @(posedge clock or negedge rst_int) begin
            if (!rst_int)          ec <= '0;
            else if (start_q)      ec <= '0;
            else if (edge_cnt_clr) ec <= rise_now ? 32'd1 : 32'd0;
            else if (rise_now)     ec <= ec + 32'd1;
        end

        assign edge_cnt[i*32 +: 32] = ec;
`endif
    end

endmodule

// File: tb/tb_clk_pattern_gen.sv
// Directed bench for clk_pattern_gen: timing table plus stop, restart, reset
// and config-latch sequences; edge counters checked when the macro is defined.
module tb_clk_pattern_gen;
    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic [N_CH-1:0]       ch_en = '0;
    logic [N_CH*CNT_W-1:0] cfg_delay = '0;
    logic [N_CH*CNT_W-1:0] cfg_neg = '0;
    logic [N_CH*CNT_W-1:0] cfg_pos = '0;
    logic [N_CH-1:0]       clock_out;
    logic [N_CH-1:0]       clock_out_n;
    logic [N_CH-1:0]       rise_stb;
    logic [N_CH-1:0]       busy;
`ifdef CLK_PATTERN_GEN_EDGE_CNT_EN
    logic                  edge_cnt_clr = 1'b0;
    logic [N_CH*32-1:0]    edge_cnt;
`endif

    clk_pattern_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .IDLE_LEVEL(1'b0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .ch_en       (ch_en),
        .cfg_delay   (cfg_delay),
        .cfg_neg     (cfg_neg),
        .cfg_pos     (cfg_pos),
`ifdef CLK_PATTERN_GEN_EDGE_CNT_EN
        .edge_cnt_clr(edge_cnt_clr),
        .edge_cnt    (edge_cnt),
`endif
        .clock_out   (clock_out),
        .clock_out_n (clock_out_n),
        .rise_stb    (rise_stb),
        .busy        (busy)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int d, input int n, input int p);
        cfg_delay[ch*CNT_W +: CNT_W] = CNT_W'(d);
        cfg_neg[ch*CNT_W +: CNT_W]   = CNT_W'(n);
        cfg_pos[ch*CNT_W +: CNT_W]   = CNT_W'(p);
    endtask

    // Returns just after the edge that samples start (k = 0).
    task automatic pulse_start(input logic [N_CH-1:0] en);
        ch_en = en;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        int ch;
        int d;
        int n;
        int p;
        int r1;
        int f1;
        int r2;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int r1m, f1m, r2m, bad_n, hi, rises, mism, act;
        logic [8:1] pat;

        // k = cycles after the start edge; rise = D + N + 1, fall = rise + P, rise2 = fall + N
        tbl[0] = '{ch: 0, d: 0, n: 2, p: 3, r1: 3, f1: 6,  r2: 8};
        tbl[1] = '{ch: 1, d: 5, n: 0, p: 0, r1: 7, f1: 8,  r2: 9};
        tbl[2] = '{ch: 2, d: 3, n: 1, p: 1, r1: 5, f1: 6,  r2: 7};
        tbl[3] = '{ch: 3, d: 0, n: 4, p: 2, r1: 5, f1: 7,  r2: 11};
        tbl[4] = '{ch: 0, d: 1, n: 3, p: 5, r1: 5, f1: 10, r2: 13};
        tbl[5] = '{ch: 2, d: 2, n: 0, p: 4, r1: 4, f1: 8,  r2: 9};

        #1 reset_n = 1'b0;
        repeat (3) tick();
        check("reset_clock_out", 32'(clock_out), 32'h0);
        check("reset_clock_out_n", 32'(clock_out_n), 32'hF);
        check("reset_rise_stb", 32'(rise_stb), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (4) tick();

        for (int v = 0; v < 6; v++) begin
            set_cfg(tbl[v].ch, tbl[v].d, tbl[v].n, tbl[v].p);
            pulse_start(N_CH'(1) << tbl[v].ch);
            exp_q = {};
            exp_q.push_back(32'(tbl[v].r1));
            exp_q.push_back(32'(tbl[v].r2));
            r1m = -1; f1m = -1; r2m = -1; bad_n = 0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (k == 1) begin
                    check($sformatf("v%0d_busy_k1", v), 32'(busy), 32'(N_CH'(1) << tbl[v].ch));
                    check($sformatf("v%0d_low_k1", v), 32'(clock_out[tbl[v].ch]), 32'd0);
                end
                if (clock_out_n !== ~clock_out) bad_n++;
                if (rise_stb[tbl[v].ch]) begin
                    if (exp_q.size() == 0) check($sformatf("v%0d_rise_stb_extra", v), 32'(k), 32'd0);
                    else check($sformatf("v%0d_rise_stb_pos", v), 32'(k), exp_q.pop_front());
                end
                if (r1m < 0 && clock_out[tbl[v].ch]) r1m = k;
                else if (r1m >= 0 && f1m < 0 && !clock_out[tbl[v].ch]) f1m = k;
                else if (f1m >= 0 && r2m < 0 && clock_out[tbl[v].ch]) r2m = k;
                if (r2m >= 0) break;
            end
            check($sformatf("v%0d_first_rise", v), 32'(r1m), 32'(tbl[v].r1));
            check($sformatf("v%0d_first_fall", v), 32'(f1m), 32'(tbl[v].f1));
            check($sformatf("v%0d_second_rise", v), 32'(r2m), 32'(tbl[v].r2));
            check($sformatf("v%0d_rise_stb_missing", v), 32'(exp_q.size()), 32'd0);
            check($sformatf("v%0d_complement", v), 32'(bad_n), 32'd0);
        end

        // stop on the second HIGH cycle: the full 4-cycle high phase still completes
        set_cfg(0, 0, 2, 4);
        pulse_start(4'b0001);
        repeat (3) tick();
        check("stop_hi_risen", 32'(clock_out[0]), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        hi = 1; rises = 0;
        for (int k = 4; k <= 12; k++) begin
            if (k > 4) tick();
            if (clock_out[0]) hi++;
            if (rise_stb[0]) rises++;
            if (k == 7) begin
                check("stop_hi_idle_busy", 32'(busy[0]), 32'd0);
                check("stop_hi_idle_level", 32'(clock_out[0]), 32'd0);
            end
        end
        check("stop_hi_len", 32'(hi), 32'd4);
        check("stop_hi_no_rise", 32'(rises), 32'd0);

        // stop during LOW and during DELAY ends the channel one edge after it is seen
        for (int j = 0; j < 2; j++) begin
            if (j == 0) set_cfg(0, 0, 5, 2);
            else        set_cfg(0, 4, 1, 1);
            pulse_start(4'b0001);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check($sformatf("stop_early%0d_busy_k1", j), 32'(busy[0]), 32'd1);
            tick();
            check($sformatf("stop_early%0d_busy_k2", j), 32'(busy[0]), 32'd0);
        end

        // restart mid-HIGH truncates the pulse and realigns timing
        set_cfg(0, 0, 2, 4);
        pulse_start(4'b0001);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_still_high", 32'(clock_out[0]), 32'd1);
        tick();
        check("restart_forced_low", 32'(clock_out[0]), 32'd0);
        check("restart_busy", 32'(busy[0]), 32'd1);
        tick();
        check("restart_low_k2", 32'(clock_out[0]), 32'd0);
        tick();
        check("restart_rise_k3", 32'(clock_out[0]), 32'd1);
        check("restart_stb_k3", 32'(rise_stb[0]), 32'd1);

        // start and stop together: start wins
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        rises = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rise_stb[0]) rises++;
        end
        check("start_stop_busy", 32'(busy[0]), 32'd1);
        check("start_stop_rises", 32'(rises), 32'd2);

        // config changes after start have no effect
        set_cfg(0, 0, 2, 3);
        pulse_start(4'b0001);
        set_cfg(0, 6, 7, 9);
        ch_en = 4'b0000;
        pat = 8'b1001_1100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("latch_k%0d", k), 32'(clock_out[0]), 32'(pat[k]));
        end

        // identical configs give identical channels
        for (int c = 0; c < N_CH; c++) set_cfg(c, 2, 1, 3);
        pulse_start(4'hF);
        mism = 0; rises = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (clock_out != {N_CH{clock_out[0]}} || rise_stb != {N_CH{rise_stb[0]}}) mism++;
            if (rise_stb[0]) rises++;
        end
        check("identical_mismatch", 32'(mism), 32'd0);
        check("identical_rises", 32'(rises), 32'd5);
        check("identical_high_k20", 32'(clock_out), 32'hF);

        // asynchronous reset between edges while all channels are high
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_clock_out", 32'(clock_out), 32'h0);
        check("async_rst_clock_out_n", 32'(clock_out_n), 32'hF);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_rise_stb", 32'(rise_stb), 32'h0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy != '0 || clock_out != '0 || rise_stb != '0) act++;
        end
        check("post_reset_quiet", 32'(act), 32'd0);
        set_cfg(0, 0, 2, 3);
        pulse_start(4'b0001);
        repeat (3) tick();
        check("post_reset_start_rise", 32'(clock_out[0]), 32'd1);

`ifdef CLK_PATTERN_GEN_EDGE_CNT_EN
        set_cfg(0, 0, 1, 1);
        pulse_start(4'b0001);
        tick();
        check("edge_cnt_cleared_by_start", edge_cnt[31:0], 32'd0);
        repeat (19) tick();
        check("edge_cnt_ten_periods", edge_cnt[31:0], 32'd10);
        tick();
        edge_cnt_clr = 1'b1;
        tick();
        edge_cnt_clr = 1'b0;
        check("edge_cnt_clr_on_rise", edge_cnt[31:0], 32'd1);
        edge_cnt_clr = 1'b1;
        tick();
        edge_cnt_clr = 1'b0;
        check("edge_cnt_clr_no_rise", edge_cnt[31:0], 32'd0);
        tick();
        check("edge_cnt_after_clr", edge_cnt[31:0], 32'd1);
        check("edge_cnt_other_ch", edge_cnt[63:32], 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clk_pattern_gen.md
Name: clk_pattern_gen

Overview:
- Synthesisable, runtime-programmable multi-channel clock/strobe pattern generator.
- Each of N_CH channels produces a divided clock from the system clock. Per channel, the start delay, low time and high time are set in clock cycles, and each channel also drives a complementary output.
- Used on-chip and in SimpleSim benches to generate sample/frame clocks for DAC/ADC datapaths. Channels are phase-aligned by a common start.

Parameters:
- N_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of each delay/low/high count field.
- IDLE_LEVEL, 0, level of clock_out while a channel is idle (clock_out_n is always its complement).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; latch config and (re)start all channels with ch_en set.
- stop  input  1  single-cycle pulse; request a glitch-free stop of all running channels.
- ch_en  input  N_CH  per-channel enable, sampled only on start.
- cfg_delay  input  N_CH*CNT_W  startup delay in cycles, channel i at [i*CNT_W +: CNT_W].
- cfg_neg  input  N_CH*CNT_W  low-phase length in cycles.
- cfg_pos  input  N_CH*CNT_W  high-phase length in cycles.
- clock_out  output  N_CH  generated clocks, registered.
- clock_out_n  output  N_CH  complement of clock_out, registered.
- rise_stb  output  N_CH  one-cycle pulse coincident with the first cycle clock_out is high.
- busy  output  N_CH  channel is in DELAY, LOW or HIGH.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - All channels go to IDLE.
  - clock_out=IDLE_LEVEL, clock_out_n=~IDLE_LEVEL, rise_stb=0, busy=0.
  - Latched config is cleared.
- Per-channel FSM states are IDLE, DELAY, LOW and HIGH, each with a CNT_W down-counter.
- Config latch: on start, cfg_delay/cfg_neg/cfg_pos for the enabled channels are latched. Later cfg changes have no effect until the next start.
- Zero counts:
  - cfg_neg=0 or cfg_pos=0 is treated as 1.
  - cfg_delay=0 skips DELAY.
- Start timing, with start sampled at edge t:
  - Enabled channel enters DELAY (or LOW if delay=0) at edge t+1, with clock_out=0 and busy=1.
  - DELAY lasts D cycles, then LOW lasts NEG cycles.
  - clock_out first rises at edge t+D+NEG+1.
  - HIGH lasts POS cycles, then LOW lasts NEG cycles, repeating. Period = POS+NEG cycles, duty = POS/(POS+NEG).
- Disabled channels on start: go to IDLE immediately at t+1.
- Start while running: restart. The channel goes to DELAY/LOW at t+1 with clock_out forced 0, even mid-HIGH. This truncated pulse is intended behaviour for resync.
- stop:
  - Sets a per-channel stop-pending flag.
  - A channel in HIGH completes its HIGH phase, then goes to IDLE instead of LOW.
  - A channel in DELAY or LOW goes to IDLE at the next edge.
  - No high pulse shorter than POS is ever produced by stop.
- start and stop in the same cycle: start wins and stop-pending is cleared.
- rise_stb: high exactly on the cycle the registered clock_out transitions 0->1; never asserted during the IDLE_LEVEL=1 idle state.
- IDLE output: clock_out returns to IDLE_LEVEL on entering IDLE.
- Channel independence: all channels share start/stop but count independently. Identical configs yield bit-identical outputs.
- Counters never wrap. Maximum phase length is 2^CNT_W-1 cycles.

Optional Feature:
- Macro: CLK_PATTERN_GEN_EDGE_CNT_EN.
- When defined:
  - Adds output port edge_cnt (N_CH*32), a per-channel 32-bit count of rising edges since the last start.
  - The count clears on start and on reset, and wraps modulo 2^32.
  - Adds input edge_cnt_clr (1), which clears all counts. If it coincides with a rise, the count is set to 1.
- When undefined: neither port exists, and no counter logic is generated.

Test Plan:
- Basic: N_CH=4, ch0 D=0 NEG=2 POS=3, start at edge 10 -> rise at 13, fall at 16, rise at 18; rise_stb at 13 and 18; clock_out_n always complementary.
- Delay/zero: ch1 D=5 NEG=0 POS=0, start at edge 10 -> busy from 11; first rise at 17; period 2 with 1-high/1-low.
- Stop mid-HIGH: ch0 NEG=2 POS=4, pulse stop on 2nd HIGH cycle -> HIGH lasts full 4 cycles, then IDLE; clock_out=IDLE_LEVEL and busy=0.
- Restart/priority: start during HIGH -> clock_out 0 at next edge and timing realigned; start+stop same cycle -> channel runs, no stop.
- Reset mid-run: drop reset_n asynchronously between edges -> outputs go to reset values immediately. After release, no activity until the next start.
- Feature on: run 10 periods -> edge_cnt=10; assert edge_cnt_clr coincident with a rise -> edge_cnt=1.
